// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and FSM state type for the UART receiver
package uart_rx_pkg;
   localparam logic [7:0]  ADR_CLK_DIV  = 8'h00;
   localparam logic [7:0]  ADR_DATA     = 8'h04;
   localparam logic [7:0]  ADR_STATUS   = 8'h08;

   localparam int          STAT_VALID   = 0;
   localparam int          STAT_OVF     = 1;
   localparam int          STAT_FERR    = 2;
   localparam int          STAT_CNT_LSB = 4;

   localparam logic [31:0] EMPTY_READ   = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_wb_if.sv
// rtl/uart_rx_wb_if.sv - Wishbone slave bus bundle for the UART receiver
interface uart_rx_wb_if;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport master (output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
                   input  wb_ack_o, wb_dat_o);
   modport slave  (input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
                   output wb_ack_o, wb_dat_o);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO, DEPTH must be a power of 2 and >= 2
module uart_rx_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB separates full from empty and wraps naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers define validity
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/uart_rx_wb.sv
// rtl/uart_rx_wb.sv - 8N1 UART receiver with FIFO and Wishbone registers; option UART_RX_FRAME_ERR_EN
module uart_rx_wb
   import uart_rx_pkg::*;
#(
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] DIV_RESET  = 32'd1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   uart_rx_wb_if.slave wb,
   input  logic        ser_rx,
   output logic        rx_valid_o,
   output logic        rx_ovf_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic        r_sync1, r_srx, r_srx_d;
   logic [31:0] r_clk_div, r_cnt, r_dat_o;
   rx_state_t   r_state;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic        r_push, r_ovf, r_ack;
   logic        w_ferr;
   logic [31:0] w_div_eff, w_rdata, w_status, w_cnt32;
   logic [3:0]  w_cnt_sat;
   logic [7:0]  w_ofs, w_fifo_dout;
   logic        w_access, w_wr, w_rd, w_pop, w_full, w_empty, w_overflow;
   logic [AW:0] w_count;

   assign w_div_eff  = (r_clk_div == 32'd0) ? 32'd1 : r_clk_div;
   assign w_access   = wb.wb_stb_i && wb.wb_cyc_i && (wb.wb_adr_i[31:8] == BASE_ADR[31:8]) && !r_ack;
   assign w_ofs      = wb.wb_adr_i[7:0];
   assign w_wr       = w_access && wb.wb_we_i;
   assign w_rd       = w_access && !wb.wb_we_i;
   assign w_pop      = w_rd && (w_ofs == ADR_DATA) && !w_empty;
   assign w_overflow = r_push && w_full && !w_pop;
   assign w_cnt32    = 32'(w_count);
   assign w_cnt_sat  = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];

   // STATUS word assembly
   always_comb begin
      w_status                     = '0;
      w_status[STAT_VALID]         = !w_empty;
      w_status[STAT_OVF]           = r_ovf;
      w_status[STAT_FERR]          = w_ferr;
      w_status[STAT_CNT_LSB +: 4]  = w_cnt_sat;
   end

   // Read data mux; unmapped offsets read as zero
   always_comb begin
      w_rdata = '0;
      case (w_ofs)
         ADR_CLK_DIV: w_rdata = r_clk_div;
         ADR_DATA:    w_rdata = w_empty ? EMPTY_READ : {24'h0, w_fifo_dout};
         ADR_STATUS:  w_rdata = w_status;
         default:     w_rdata = '0;
      endcase
   end

   // Two-flop synchroniser plus one delayed copy for start-edge detection
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_sync1 <= 1'b1;
         r_srx   <= 1'b1;
         r_srx_d <= 1'b1;
      end else begin
         r_sync1 <= ser_rx;
         r_srx   <= r_sync1;
         r_srx_d <= r_srx;
      end
   end

   // Bus side: single-cycle ack, read data, CLK_DIV byte-lane writes, sticky overflow
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_ack     <= 1'b0;
         r_dat_o   <= '0;
         r_clk_div <= DIV_RESET;
         r_ovf     <= 1'b0;
      end else begin
         r_ack   <= w_access;
         r_dat_o <= w_rd ? w_rdata : 32'h0;
         if (w_wr && (w_ofs == ADR_CLK_DIV)) begin
            for (int i = 0; i < 4; i++) begin
               if (wb.wb_sel_i[i]) r_clk_div[8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
            end
         end
         // A new overflow takes priority over a simultaneous clear
         if (w_overflow)
            r_ovf <= 1'b1;
         else if (w_wr && (w_ofs == ADR_STATUS) && wb.wb_sel_i[0] && wb.wb_dat_i[STAT_OVF])
            r_ovf <= 1'b0;
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   logic r_ferr;
   assign w_ferr = r_ferr;
`else
   assign w_ferr = 1'b0;
`endif

   // Receive FSM: mid-bit sampling with a down-counter reloaded from CLK_DIV each bit
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_push    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         r_ferr    <= 1'b0;
`endif
      end else begin
         r_push <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         if (w_wr && (w_ofs == ADR_STATUS) && wb.wb_sel_i[0] && wb.wb_dat_i[STAT_FERR])
            r_ferr <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (!r_srx && r_srx_d) begin
                  r_cnt   <= w_div_eff >> 1;
                  r_state <= START;
               end
            end
            START: begin
               if (r_cnt == 32'd0) begin
                  if (!r_srx) begin
                     r_cnt     <= w_div_eff;
                     r_bit_idx <= '0;
                     r_state   <= DATA;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            DATA: begin
               if (r_cnt == 32'd0) begin
                  r_shift   <= {r_srx, r_shift[7:1]};
                  r_cnt     <= w_div_eff;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            STOP: begin
               if (r_cnt == 32'd0) begin
`ifdef UART_RX_FRAME_ERR_EN
                  if (!r_srx) begin
                     r_ferr  <= 1'b1;
                     r_state <= BREAK;
                  end else begin
                     r_push  <= 1'b1;
                     r_state <= IDLE;
                  end
`else
                  r_push  <= 1'b1;
                  r_state <= IDLE;
`endif
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            BREAK: begin
               if (r_srx) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // r_shift is stable while the push pulse is high, so it feeds the FIFO directly
   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rstn_i),
      .i_push  (r_push),
      .i_din   (r_shift),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat_o;
   assign rx_valid_o  = !w_empty;
   assign rx_ovf_o    = r_ovf;
endmodule
